// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int CNT_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the requester that was not granted last. The pointer advances on update.
module mem_arb_rr (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_idx
);

    logic last_q;
    logic last_d;

    // Choose the winner from the current requests and the last-granted pointer
    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last_q;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

    // Remember the winner only when the arbiter actually accepts a request
    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = gnt_idx;
        end
    end

    // Pointer register; starting at "last=1" lets m0 win the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with fully registered outputs.
// Optional grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  m0_gnt_cnt,
    output logic [CNT_WIDTH-1:0]  m1_gnt_cnt
`endif
);

    arb_state_e            state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  m0_gnt_q, m0_gnt_d;
    logic                  m1_gnt_q, m1_gnt_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  m0_rvalid_q, m0_rvalid_d;
    logic                  m1_rvalid_q, m1_rvalid_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  busy_q, busy_d;
    logic                  rr_idx;
    logic                  rr_update;

    mem_arb_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({m1_req, m0_req}),
        .update  (rr_update),
        .gnt_idx (rr_idx)
    );

    // Next-state and next-output logic; the memory strobes, grant and
    // address/data are the captured request presented during ISSUE only
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_update   = 1'b0;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d     = ISSUE;
                    sel_d       = rr_idx;
                    rr_update   = 1'b1;
                    m0_gnt_d    = ~rr_idx;
                    m1_gnt_d    = rr_idx;
                    mem_wr_en_d = rr_idx ? m1_wr : m0_wr;
                    mem_rd_en_d = ~mem_wr_en_d;
                    mem_addr_d  = rr_idx ? m1_addr : m0_addr;
                    mem_wdata_d = rr_idx ? m1_wdata : m0_wdata;
                end
            end
            ISSUE: begin
                state_d = mem_rd_en_q ? RD_WAIT : IDLE;
            end
            RD_WAIT: begin
                state_d = IDLE;
                if (sel_q) begin
                    m1_rvalid_d = 1'b1;
                    m1_rdata_d  = mem_rdata;
                end else begin
                    m0_rvalid_d = 1'b1;
                    m0_rdata_d  = mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign busy      = busy_q;

`ifdef MEM_ARB_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] m0_cnt_q, m0_cnt_d;
    logic [CNT_WIDTH-1:0] m1_cnt_q, m1_cnt_d;

    // Saturating per-requester grant counters, stepped alongside the grant
    always_comb begin
        m0_cnt_d = m0_cnt_q;
        m1_cnt_d = m1_cnt_q;
        if (m0_gnt_d && (m0_cnt_q != CNT_MAX)) begin
            m0_cnt_d = m0_cnt_q + CNT_WIDTH'(1);
        end
        if (m1_gnt_d && (m1_cnt_q != CNT_MAX)) begin
            m1_cnt_d = m1_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_cnt_q <= '0;
            m1_cnt_q <= '0;
        end else begin
            m0_cnt_q <= m0_cnt_d;
            m1_cnt_q <= m1_cnt_d;
        end
    end

    assign m0_gnt_cnt = m0_cnt_q;
    assign m1_gnt_cnt = m1_cnt_q;
`else
    // Grant statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle-by-cycle vector table plus
// hand-written round-robin and grant-counter sequences (MEM_ARB_STATS_EN).
module tb_mem_arbiter;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [1:0]  a0;
        logic [7:0]  d0;
        logic        r1;
        logic        w1;
        logic [1:0]  a1;
        logic [7:0]  d1;
        logic [32:0] expected;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic [1:0] mem_addr;
    logic       mem_wr_en, mem_rd_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] m0_gnt_cnt, m1_gnt_cnt;
`endif

    logic [7:0] mem_model [4] = '{default: 8'h00};

    int checks;
    int errors;

    vec_t tbl [16];

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .m0_gnt_cnt (m0_gnt_cnt),
        .m1_gnt_cnt (m1_gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memory: writes land on the strobe edge, read data is valid the
    // cycle after mem_rd_en
    always @(posedge clk) begin
        if (reset) begin
            mem_rdata <= 8'h00;
        end else begin
            if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
        end
    end

    function automatic logic [32:0] expo(input logic g0, input logic g1,
                                         input logic we, input logic re,
                                         input logic [1:0] ma, input logic [7:0] md,
                                         input logic v0, input logic v1,
                                         input logic [7:0] rd0, input logic [7:0] rd1,
                                         input logic bz);
        return {g0, g1, we, re, ma, md, v0, v1, rd0, rd1, bz};
    endfunction

    function automatic vec_t mkv(input logic rst,
                                 input logic r0, input logic w0, input logic [1:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [1:0] a1, input logic [7:0] d1,
                                 input logic [32:0] e);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.expected = e;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        m0_req   = v.r0;
        m0_wr    = v.w0;
        m0_addr  = v.a0;
        m0_wdata = v.d0;
        m1_req   = v.r1;
        m1_wr    = v.w1;
        m1_addr  = v.a1;
        m1_wdata = v.d1;
    endtask

    task automatic checkOutput(input int row, input logic [32:0] expected);
        logic [32:0] actual;
        actual = {m0_gnt, m1_gnt, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
                  m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, busy};
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL row%0d outputs {g0,g1,we,re,addr,wdata,v0,v1,rd0,rd1,busy}: got %h expected %h",
                     row, actual, expected);
        end
    endtask

    task automatic doReset();
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Both requesters hold write requests; grants must alternate starting
    // with m0 after reset and never overlap
    task automatic runAlternating(input int n_grants);
        int got;
        int exp_idx;
        got     = 0;
        exp_idx = 0;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 2'd0; m0_wdata = 8'h10;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 2'd1; m1_wdata = 8'h20;
        for (int c = 0; c < 64 && got < n_grants; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (m0_gnt && m1_gnt) begin
                errors++;
                $display("[TB] FAIL gnt_overlap cycle%0d: got m0_gnt=%0d m1_gnt=%0d expected at most one",
                         c, m0_gnt, m1_gnt);
            end
            if (m0_gnt || m1_gnt) begin
                checks++;
                if (int'(m1_gnt) != exp_idx) begin
                    errors++;
                    $display("[TB] FAIL rr_order grant%0d: got idx %0d expected %0d",
                             got, int'(m1_gnt), exp_idx);
                end
                exp_idx ^= 1;
                got++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        checks++;
        if (got != n_grants) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d grants expected %0d", got, n_grants);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            rst r0 w0 a0    d0     r1 w1 a1    d1     g0 g1 we re ma    md     v0 v1 rd0    rd1    busy
        tbl[0]  = mkv(1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl[1]  = mkv(0, 1, 1, 2'd2, 8'hA5, 0, 0, 2'd0, 8'h00, expo(1, 0, 1, 0, 2'd2, 8'hA5, 0, 0, 8'h00, 8'h00, 1));
        tbl[2]  = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl[3]  = mkv(0, 0, 0, 2'd0, 8'h00, 1, 0, 2'd2, 8'h00, expo(0, 1, 0, 1, 2'd2, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl[4]  = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl[5]  = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 1, 8'h00, 8'hA5, 0));
        tbl[6]  = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'hA5, 0));
        tbl[7]  = mkv(1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl[8]  = mkv(0, 1, 1, 2'd1, 8'h11, 1, 1, 2'd3, 8'h33, expo(1, 0, 1, 0, 2'd1, 8'h11, 0, 0, 8'h00, 8'h00, 1));
        tbl[9]  = mkv(0, 0, 0, 2'd0, 8'h00, 1, 1, 2'd3, 8'h33, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl[10] = mkv(0, 0, 0, 2'd0, 8'h00, 1, 1, 2'd3, 8'h33, expo(0, 1, 1, 0, 2'd3, 8'h33, 0, 0, 8'h00, 8'h00, 1));
        tbl[11] = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl[12] = mkv(0, 1, 0, 2'd3, 8'h00, 0, 0, 2'd0, 8'h00, expo(1, 0, 0, 1, 2'd3, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl[13] = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl[14] = mkv(1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl[15] = mkv(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, expo(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));

        // Each row is held for one clock and the registered outputs are
        // compared just after the edge
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
            @(posedge clk);
            #1;
            checkOutput(i, tbl[i].expected);
        end

        $display("[TB] round-robin sequence with continuous requests");
        doReset();
        runAlternating(8);

        doReset();
        runAlternating(5);
`ifdef MEM_ARB_STATS_EN
        checks++;
        if (m0_gnt_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL m0_gnt_cnt: got %0d expected 3", m0_gnt_cnt);
        end
        checks++;
        if (m1_gnt_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL m1_gnt_cnt: got %0d expected 2", m1_gnt_cnt);
        end
        doReset();
        checks++;
        if ((m0_gnt_cnt !== 16'd0) || (m1_gnt_cnt !== 16'd0)) begin
            errors++;
            $display("[TB] FAIL gnt_cnt_reset: got %0d/%0d expected 0/0", m0_gnt_cnt, m1_gnt_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 2, memory address width.
- DATA_WIDTH, 8, memory data width.

REQ-002 Ports (name  direction  width  meaning), one per line:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_req  in  1  requester N (N=0,1) transaction request.
- mN_wr  in  1  1=write, 0=read.
- mN_addr  in  ADDR_WIDTH  requester address.
- mN_wdata  in  DATA_WIDTH  requester write data.
- mN_gnt  out  1  one-cycle acceptance pulse.
- mN_rvalid  out  1  one-cycle read-response pulse.
- mN_rdata  out  DATA_WIDTH  read data, valid while mN_rvalid=1.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wr_en  out  1  to memory wr_en.
- mem_rd_en  out  1  to memory rd_en.
- mem_wdata  out  DATA_WIDTH  to memory wdata.
- mem_rdata  in  DATA_WIDTH  from memory rdata; valid on the cycle after mem_rd_en.
- busy  out  1  high whenever FSM is not IDLE.

Function
REQ-003 FSM states IDLE, ISSUE, RD_WAIT; all outputs SHALL be registered.
REQ-004 In IDLE, if any mN_req=1 at edge T, the winner's wr/addr/wdata SHALL be captured and the FSM SHALL enter ISSUE; no request -> stay IDLE.
REQ-005 ISSUE (cycle T+1) SHALL assert mN_gnt for the winner and exactly one of mem_wr_en/mem_rd_en with the captured addr/wdata, all for exactly one cycle.
REQ-006 Writes: ISSUE -> IDLE, giving a 2-cycle occupancy. Reads: ISSUE -> RD_WAIT -> IDLE; mem_rdata SHALL be captured at the end of RD_WAIT, and winner mN_rvalid/mN_rdata SHALL be high in cycle T+3.
REQ-007 Arbitration in the cycle carrying rvalid SHALL be permitted (IDLE); the non-winner's rvalid SHALL stay 0.
REQ-008 Single requester SHALL win regardless of history; simultaneous requests SHALL go to the requester not granted last (round-robin pointer).
REQ-009 Requesters SHALL hold req/wr/addr/wdata stable until gnt is sampled; a req still high in the next IDLE is a new transaction.
REQ-010 Requests arriving during ISSUE/RD_WAIT SHALL be ignored until IDLE; no request SHALL be lost while held.
REQ-011 mN_rdata SHALL hold its last value when rvalid=0.

Reset
REQ-012 Reset (synchronous, active-high) SHALL force IDLE and 0 on every output; the round-robin pointer SHALL reset to "last=1", so m0 wins the first tie.
REQ-013 Reset during ISSUE/RD_WAIT SHALL abort the transaction; no rvalid SHALL be produced for it.

Configuration
REQ-014 With MEM_ARB_STATS_EN defined, ports m0_gnt_cnt/m1_gnt_cnt (out, 16) SHALL count that requester's grants, saturating at 0xFFFF, and reset to 0.
REQ-015 Without MEM_ARB_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-016 Package mem_arb_pkg SHALL hold the FSM state enum, CNT_WIDTH=16 and default width constants.
REQ-017 Sub-module mem_arb_rr (2-way round-robin picker: req[1:0], update, grant index) SHALL implement REQ-008.

Verification
REQ-018 m0 writes addr 2 data 0xA5 alone -> m0_gnt and mem_wr_en/addr=2/wdata=0xA5 at T+1 for one cycle; busy high one cycle.
REQ-019 m1 reads addr 2 after REQ-018 -> mem_rd_en at T+1; m1_rvalid=1, m1_rdata=0xA5 at T+3; m0_rvalid stays 0.
REQ-020 Both request writes in the first cycle after reset -> m0 granted at T+1; m1 granted at T+3.
REQ-021 Both hold continuous write requests for 8 grants -> grants alternate 0,1,0,1,...; no cycle has both gnt high.
REQ-022 Reset asserted during RD_WAIT -> next cycle all outputs 0, FSM IDLE, no rvalid.
REQ-023 With MEM_ARB_STATS_EN, 3 m0 grants and 2 m1 grants -> m0_gnt_cnt=3, m1_gnt_cnt=2; the build without the macro compiles and passes REQ-018 to REQ-022.
